// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single memory port of the multicycle MIPS core.
// Port 0 is the CPU and port 1 is the program loader/DMA. Each granted
// transaction runs through IDLE -> ACCESS (MEM_LAT cycles) -> DONE. Ties go
// round-robin, and every memory-side output comes straight from a flop.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 16,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  // CPU port
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [1:0]    p0_mode,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  // Loader / DMA port
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [1:0]    p1_mode,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  // Shared response
  output logic [DW-1:0] rdata,
  output logic          busy,
  // Memory side
  input  logic [DW-1:0] memData,
  output logic          MemWrite,
  output logic [1:0]    MemMode,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] writeMemData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // The counter needs at least one bit, even when MEM_LAT is 1.
  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;       // port that was served most recently
  logic          owner_q, owner_d;     // port that owns the current transaction
  logic          we_q, we_d;
  logic          mem_write_q, mem_write_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;

  // Winner if a grant happens this cycle: the single requester, or on a
  // tie the port that was not served last.
  logic sel_port;
  assign sel_port = (p0_req && p1_req) ? ~last_q : p1_req;

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    // NOTE: every target gets a default before the case; a path that skips
    // an assignment would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_write_d = 1'b0;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          owner_d     = sel_port;
          we_d        = sel_port ? p1_we    : p0_we;
          mode_d      = sel_port ? p1_mode  : p0_mode;
          addr_d      = sel_port ? p1_addr  : p0_addr;
          wdata_d     = sel_port ? p1_wdata : p0_wdata;
          // The write strobe covers only the first ACCESS cycle.
          mem_write_d = sel_port ? p1_we    : p0_we;
          cnt_d       = CNT_INIT;
          state_d     = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rdata_d = memData;
          end
          // The ack flop is set on entry to DONE, so it is high exactly there.
          p0_ack_d = (owner_q == 1'b0);
          p1_ack_d = (owner_q == 1'b1);
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; the async reset aborts any transaction at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_write_q <= 1'b0;
      mode_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the
      // values from before the edge no matter what order the lines are in.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_write_q <= mem_write_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
    end
  end

  assign MemWrite     = mem_write_q;
  assign MemMode      = mode_q;
  assign memAddr      = addr_q;
  assign writeMemData = wdata_q;
  assign rdata        = rdata_q;
  assign p0_ack       = p0_ack_q;
  assign p1_ack       = p1_ack_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. It uses one MEM_LAT=2 instance for
// most scenarios and a MEM_LAT=1 instance for back-to-back reads.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;

  // MEM_LAT=2 instance signals
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [1:0]  p0_mode, p1_mode;
  logic [15:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack, busy;
  logic [31:0] rdata, mem_data;
  logic        mem_write;
  logic [1:0]  mem_mode;
  logic [15:0] mem_addr;
  logic [31:0] write_mem_data;

  // MEM_LAT=1 instance signals (only port 0 is exercised)
  logic        q0_req, q0_we, q1_req, q1_we;
  logic [1:0]  q0_mode, q1_mode;
  logic [15:0] q0_addr, q1_addr;
  logic [31:0] q0_wdata, q1_wdata;
  logic        q0_ack, q1_ack, busy1;
  logic [31:0] rdata1, mem_data1;
  logic        mem_write1;
  logic [1:0]  mem_mode1;
  logic [15:0] mem_addr1;
  logic [31:0] write_mem_data1;

  int n_checks;
  int n_fail;

  mem_port_arbiter #(.MEM_LAT(2), .AW(16), .DW(32)) u_dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_mode(p0_mode), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_mode(p1_mode), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .busy(busy), .memData(mem_data), .MemWrite(mem_write),
    .MemMode(mem_mode), .memAddr(mem_addr), .writeMemData(write_mem_data)
  );

  mem_port_arbiter #(.MEM_LAT(1), .AW(16), .DW(32)) u_dut1 (
    .clk(clk), .reset(reset),
    .p0_req(q0_req), .p0_we(q0_we), .p0_mode(q0_mode), .p0_addr(q0_addr),
    .p0_wdata(q0_wdata), .p0_ack(q0_ack),
    .p1_req(q1_req), .p1_we(q1_we), .p1_mode(q1_mode), .p1_addr(q1_addr),
    .p1_wdata(q1_wdata), .p1_ack(q1_ack),
    .rdata(rdata1), .busy(busy1), .memData(mem_data1), .MemWrite(mem_write1),
    .MemMode(mem_mode1), .memAddr(mem_addr1), .writeMemData(write_mem_data1)
  );

  // Memory model for the MEM_LAT=1 instance: each word returns a tag plus its address.
  assign mem_data1 = 32'hC0DE_0000 | {16'h0000, mem_addr1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the directed sequence below is far shorter than this.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    {p0_req, p0_we, p1_req, p1_we} = '0;
    {p0_mode, p1_mode} = '0;
    {p0_addr, p1_addr} = '0;
    {p0_wdata, p1_wdata} = '0;
    mem_data = '0;
    {q0_req, q0_we, q1_req, q1_we} = '0;
    {q0_mode, q1_mode} = '0;
    {q0_addr, q1_addr} = '0;
    {q0_wdata, q1_wdata} = '0;

    // T1: reset held with random inputs -> all outputs zero
    for (int i = 0; i < 5; i++) begin
      p0_req = 1'($urandom); p0_we = 1'($urandom); p0_mode = 2'($urandom);
      p0_addr = 16'($urandom); p0_wdata = $urandom;
      p1_req = 1'($urandom); p1_we = 1'($urandom); p1_mode = 2'($urandom);
      p1_addr = 16'($urandom); p1_wdata = $urandom;
      mem_data = $urandom;
      tick();
    end
    check("t1_memwrite", 64'(mem_write), 64'd0);
    check("t1_memmode", 64'(mem_mode), 64'd0);
    check("t1_memaddr", 64'(mem_addr), 64'd0);
    check("t1_wmemdata", 64'(write_mem_data), 64'd0);
    check("t1_rdata", 64'(rdata), 64'd0);
    check("t1_p0_ack", 64'(p0_ack), 64'd0);
    check("t1_p1_ack", 64'(p1_ack), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    {p0_req, p1_req, p0_we, p1_we} = '0;
    reset = 1'b1;
    tick();
    check("t1_idle_memwrite_a", 64'(mem_write), 64'd0);
    tick();
    check("t1_idle_memwrite_b", 64'(mem_write), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // T2: single CPU read, ack at t+3
    mem_data = 32'hDEAD_BEEF;
    p0_req = 1'b1; p0_we = 1'b0; p0_mode = 2'b10; p0_addr = 16'h0040;
    tick();
    check("t2_addr_c1", 64'(mem_addr), 64'h0040);
    check("t2_mw_c1", 64'(mem_write), 64'd0);
    check("t2_mode_c1", 64'(mem_mode), 64'd2);
    check("t2_busy_c1", 64'(busy), 64'd1);
    check("t2_ack_c1", 64'(p0_ack), 64'd0);
    tick();
    check("t2_addr_c2", 64'(mem_addr), 64'h0040);
    check("t2_mw_c2", 64'(mem_write), 64'd0);
    check("t2_ack_c2", 64'(p0_ack), 64'd0);
    tick();
    check("t2_p0_ack_c3", 64'(p0_ack), 64'd1);
    check("t2_p1_ack_c3", 64'(p1_ack), 64'd0);
    check("t2_rdata", 64'(rdata), 64'hDEAD_BEEF);
    check("t2_busy_done", 64'(busy), 64'd1);
    p0_req = 1'b0;
    tick();
    check("t2_ack_drop", 64'(p0_ack), 64'd0);
    check("t2_busy_idle", 64'(busy), 64'd0);

    // T3: loader write, single-cycle strobe, rdata unchanged
    mem_data = 32'h5555_5555;
    p1_req = 1'b1; p1_we = 1'b1; p1_mode = 2'b01; p1_addr = 16'h0100;
    p1_wdata = 32'h1234_5678;
    tick();
    check("t3_mw_c1", 64'(mem_write), 64'd1);
    check("t3_mode_c1", 64'(mem_mode), 64'd1);
    check("t3_addr_c1", 64'(mem_addr), 64'h0100);
    check("t3_wdata_c1", 64'(write_mem_data), 64'h1234_5678);
    tick();
    check("t3_mw_c2", 64'(mem_write), 64'd0);
    check("t3_addr_c2", 64'(mem_addr), 64'h0100);
    check("t3_wdata_c2", 64'(write_mem_data), 64'h1234_5678);
    check("t3_ack_c2", 64'(p1_ack), 64'd0);
    tick();
    check("t3_p1_ack_c3", 64'(p1_ack), 64'd1);
    check("t3_p0_ack_c3", 64'(p0_ack), 64'd0);
    check("t3_mw_c3", 64'(mem_write), 64'd0);
    check("t3_rdata_kept", 64'(rdata), 64'hDEAD_BEEF);
    p1_req = 1'b0; p1_we = 1'b0;
    tick();
    check("t3_ack_drop", 64'(p1_ack), 64'd0);

    // T4: contention from reset -> p0,p1,p0,p1 at cycles 3,7,11,15
    reset = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0020;
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("t4_p0_ack_c%0d", i), 64'(p0_ack), 64'((i == 3) || (i == 11)));
      check($sformatf("t4_p1_ack_c%0d", i), 64'(p1_ack), 64'((i == 7) || (i == 15)));
      if (i == 1) check("t4_addr_first", 64'(mem_addr), 64'h0010);
      if (i == 5) check("t4_addr_second", 64'(mem_addr), 64'h0020);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    check("t4_busy_end", 64'(busy), 64'd0);

    // T5: reset in the 2nd ACCESS cycle of a write, then clean restart
    p0_req = 1'b1; p0_we = 1'b1; p0_mode = 2'b11; p0_addr = 16'h0080;
    p0_wdata = 32'hAAAA_5555;
    tick();
    check("t5_mw_c1", 64'(mem_write), 64'd1);
    tick();
    check("t5_busy_c2", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_abort_mw", 64'(mem_write), 64'd0);
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_addr", 64'(mem_addr), 64'd0);
    tick();
    check("t5_no_ack", 64'(p0_ack), 64'd0);
    reset = 1'b1;
    tick();
    check("t5_re_mw", 64'(mem_write), 64'd1);
    check("t5_re_addr", 64'(mem_addr), 64'h0080);
    check("t5_re_wdata", 64'(write_mem_data), 64'hAAAA_5555);
    tick();
    check("t5_re_ack_c2", 64'(p0_ack), 64'd0);
    tick();
    check("t5_re_ack_c3", 64'(p0_ack), 64'd1);
    p0_req = 1'b0; p0_we = 1'b0;
    tick();

    // T6: MEM_LAT=1 back-to-back reads, acks at t+2 and t+5
    q0_req = 1'b1; q0_we = 1'b0; q0_addr = 16'h0000;
    tick();
    check("t6_addr_a", 64'(mem_addr1), 64'h0000);
    check("t6_busy_a", 64'(busy1), 64'd1);
    check("t6_ack_c1", 64'(q0_ack), 64'd0);
    tick();
    check("t6_ack_c2", 64'(q0_ack), 64'd1);
    check("t6_rdata_a", 64'(rdata1), 64'hC0DE_0000);
    q0_addr = 16'h0004;
    tick();
    check("t6_ack_c3", 64'(q0_ack), 64'd0);
    check("t6_busy_c3", 64'(busy1), 64'd0);
    tick();
    check("t6_addr_b", 64'(mem_addr1), 64'h0004);
    check("t6_ack_c4", 64'(q0_ack), 64'd0);
    tick();
    check("t6_ack_c5", 64'(q0_ack), 64'd1);
    check("t6_rdata_b", 64'(rdata1), 64'hC0DE_0004);
    check("t6_q1_ack", 64'(q1_ack), 64'd0);
    q0_req = 1'b0;
    tick();
    check("t6_ack_drop", 64'(q0_ack), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
